// File: rtl/serial_subtractor_32bit_pkg.sv
// Shared definitions for the digit-serial subtractor: word size, default digit width, FSM states.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package serial_subtractor_32bit_pkg;
  localparam int WORD_W          = `WORD_SIZE;
  localparam int DEFAULT_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_subtractor_32bit_digit_subtractor.sv
// One DIGIT_W-bit slice of the borrow chain: adds minuend digit, pre-inverted subtrahend digit and carry.
module digit_subtractor
  import serial_subtractor_32bit_pkg::*;
#(
  parameter int DIGIT_W = DEFAULT_DIGIT_W
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] nb,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, nb} + {{DIGIT_W{1'b0}}, cin};

endmodule

// File: rtl/serial_subtractor_32bit.sv
// Digit-serial subtractor diff = a - b - bin, DIGIT_W bits per clock, valid/ready on both sides.
// Optional signed-overflow flag is built only when SUB_OVF_EN is defined.
module serial_subtractor_32bit
  import serial_subtractor_32bit_pkg::*;
#(
  parameter int DIGIT_W = DEFAULT_DIGIT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [`WORD_SIZE-1:0] a,
  input  logic [`WORD_SIZE-1:0] b,
  input  logic                  bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [`WORD_SIZE-1:0] diff,
  output logic                  bout,
  output logic                  ovf
);

  localparam int N     = WORD_W / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   a_sh, nb_sh;
  logic                carry;
  logic [CNT_W-1:0]    cnt;
  logic [DIGIT_W-1:0]  sum;
  logic                cout;
  logic                accept;
  logic                last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (state == RUN) && (cnt == LAST);

  digit_subtractor #(.DIGIT_W(DIGIT_W)) u_digit (
    .a   (a_sh[DIGIT_W-1:0]),
    .nb  (nb_sh[DIGIT_W-1:0]),
    .cin (carry),
    .sum (sum),
    .cout(cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands shift right one digit per RUN cycle so the slice always sees the current digit at bit 0.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh  <= a;
      nb_sh <= ~b;
      carry <= ~bin;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> DIGIT_W;
      nb_sh <= nb_sh >> DIGIT_W;
      carry <= cout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == RUN) begin
      diff[cnt*DIGIT_W +: DIGIT_W] <= sum;
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) bout <= ~cout;
    end
  end

`ifdef SUB_OVF_EN
  // On the last digit the low slice holds the MSBs; b's sign is the inverse of the stored nb MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (last) begin
      ovf <= (a_sh[DIGIT_W-1] == nb_sh[DIGIT_W-1]) & (sum[DIGIT_W-1] != a_sh[DIGIT_W-1]);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor_32bit.sv
// Scoreboard bench for serial_subtractor_32bit: directed vectors, back-pressure, mid-run reset, random ops.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module tb_serial_subtractor_32bit;
  localparam int W   = `WORD_SIZE;
  localparam int LAT = 9;
`ifdef SUB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic prev_ov = 1'b0;
  logic rand_ready = 1'b0;

  serial_subtractor_32bit dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain wide arithmetic for diff/borrow, true signed range test for overflow.
  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin);
    exp_t   e;
    logic [W:0] wide;
    longint s;
    wide = {1'b0, xa} - {1'b0, xb} - {{W{1'b0}}, xbin};
    e.d  = wide[W-1:0];
    e.bo = wide[W];
    s    = longint'($signed(xa)) - longint'($signed(xb)) - longint'(xbin);
    e.ov = OVF_ON & ((s > 64'sd2147483647) || (s < -64'sd2147483648));
    e.acc = 0;
    return e;
  endfunction

  // Called on a negedge; leaves in_valid high so later calls exercise the ignore-while-busy path.
  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                      input logic [W-1:0] ed, input logic eb, input logic eo);
    exp_t e;
    int   n = 0;
    a = xa; b = xb; bin = xbin; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      e.d = ed; e.bo = eb; e.ov = eo; e.acc = cyc;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic send_rand(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin);
    exp_t e;
    e = model(xa, xb, xbin);
    send(xa, xb, xbin, e.d, e.bo, e.ov);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  always @(posedge clk) begin
    #2;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) chk("spurious_out_valid", 64'(out_valid), 64'd0);
        else chk("latency", 64'(cyc - q[0].acc), 64'(LAT));
      end
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("diff", 64'(diff), 64'(e.d));
        chk("bout", 64'(bout), 64'(e.bo));
        chk("ovf", 64'(ovf), 64'(e.ov));
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_diff", 64'(diff), 64'd0);
    chk("rst_bout", 64'(bout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    send(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    send(32'h8765_4321, 32'h1234_5678, 1'b1, 32'h7530_ECA8, 1'b0, OVF_ON);
    send(32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, OVF_ON);
    send(32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    drain();

    // Back-pressure in DONE
    out_ready = 1'b0;
    send(32'h8765_4321, 32'h1234_5678, 1'b1, 32'h7530_ECA8, 1'b0, OVF_ON);
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reached_done", 64'(out_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_diff_hold", 64'(diff), 64'h7530_ECA8);
      chk("bp_bout_hold", 64'(bout), 64'd0);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_out_valid_high", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);

    // Asynchronous reset during RUN cycle 3
    send(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_diff", 64'(diff), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_bout", 64'(bout), 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    drain();

    // Randomized traffic with random consumer stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: begin ra = '0; rb = '0; end
        2: ra = '1;
        3: rb = '1;
        default: ;
      endcase
      send_rand(ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 12)) @(negedge clk);
      end
    end
    drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
